// File: rtl/map_table_ckpt_pkg.sv
// Shared rename types: physical-register tag with ready bit, map array, and map helpers.
package map_table_ckpt_pkg;

    localparam int unsigned ARCH_REGS        = 32;
    localparam int unsigned PHYS_REGS        = 64;
    localparam int unsigned WIDTH            = 2;
    localparam int unsigned CDB_WIDTH        = 2;
    localparam int unsigned NUM_CKPT         = 4;
    localparam int unsigned REG_IDX_SZ       = $clog2(ARCH_REGS);
    localparam int unsigned PHYS_REG_IDX_SZ  = $clog2(PHYS_REGS);
    localparam int unsigned CKPT_IDX_SZ      = $clog2(NUM_CKPT);
    localparam int unsigned CKPT_CNT_SZ      = CKPT_IDX_SZ + 1;

    localparam logic [REG_IDX_SZ-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic [PHYS_REG_IDX_SZ-1:0] reg_num;
        logic                       ready;
    } PREG;

    typedef PREG [ARCH_REGS-1:0] MAP_T;

    typedef logic [CDB_WIDTH-1:0][PHYS_REG_IDX_SZ-1:0] cdb_tags_t;

    // Reset image: every arch reg maps to the same-numbered preg, all ready.
    function automatic MAP_T identity_map();
        MAP_T m;
        for (int i = 0; i < int'(ARCH_REGS); i++) begin
            m[i] = '{reg_num: PHYS_REG_IDX_SZ'(i), ready: 1'b1};
        end
        return m;
    endfunction

    function automatic MAP_T apply_cdb(input MAP_T m, input logic [CDB_WIDTH-1:0] v,
                                       input cdb_tags_t t);
        MAP_T r;
        r = m;
        for (int i = 0; i < int'(ARCH_REGS); i++) begin
            for (int c = 0; c < int'(CDB_WIDTH); c++) begin
                if (v[c] && (m[i].reg_num == t[c])) begin
                    r[i].ready = 1'b1;
                end
            end
        end
        return r;
    endfunction

    // Youngest older lane writing the same arch reg overrides the map entry.
    function automatic PREG bypass_read(input logic [REG_IDX_SZ-1:0] a, input int unsigned lane,
                                        input logic [WIDTH-1:0] dv,
                                        input logic [WIDTH-1:0][REG_IDX_SZ-1:0] da,
                                        input logic [WIDTH-1:0][PHYS_REG_IDX_SZ-1:0] dn,
                                        input MAP_T m);
        PREG r;
        r = m[a];
        for (int unsigned k = 0; k < WIDTH; k++) begin
            if ((k < lane) && dv[k] && (da[k] == a)) begin
                r = '{reg_num: dn[k], ready: 1'b0};
            end
        end
        if (a == ZERO_REG) begin
            r = '{reg_num: '0, ready: 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/map_ckpt_slot.sv
// One checkpoint snapshot of the speculative map; tracks CDB wakeups while live.
module map_ckpt_slot
    import map_table_ckpt_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  MAP_T                 i_load_map,
    input  logic                 i_clear,
    input  logic [CDB_WIDTH-1:0] i_cdb_valid,
    input  cdb_tags_t            i_cdb_preg,
    output MAP_T                 o_map
);

    logic r_valid;
    MAP_T r_map;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_load) begin
            r_map <= i_load_map;
        end else if (r_valid) begin
            r_map <= apply_cdb(r_map, i_cdb_valid, i_cdb_preg);
        end
    end

    assign o_map = r_map;

endmodule

// File: rtl/map_table_ckpt.sv
// N-wide rename map table with intra-group bypass, CDB forwarding, branch checkpoints
// and an architectural map for exception flush.
module map_table_ckpt
    import map_table_ckpt_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [WIDTH-1:0][REG_IDX_SZ-1:0]          i_src1_arch,
    input  logic [WIDTH-1:0][REG_IDX_SZ-1:0]          i_src2_arch,
    output PREG  [WIDTH-1:0]                          o_src1_preg,
    output PREG  [WIDTH-1:0]                          o_src2_preg,
    input  logic [WIDTH-1:0]                          i_dest_valid,
    input  logic [WIDTH-1:0][REG_IDX_SZ-1:0]          i_dest_arch,
    input  logic [WIDTH-1:0][PHYS_REG_IDX_SZ-1:0]     i_dest_new_preg,
    output PREG  [WIDTH-1:0]                          o_dest_old_preg,
    input  logic [CDB_WIDTH-1:0]                      i_cdb_valid,
    input  cdb_tags_t                                 i_cdb_preg,
    input  logic                                      i_ckpt_alloc,
    output logic [CKPT_IDX_SZ-1:0]                    o_ckpt_id,
    output logic                                      o_ckpt_full,
    input  logic                                      i_ckpt_release,
    input  logic                                      i_ckpt_restore,
    input  logic [CKPT_IDX_SZ-1:0]                    i_ckpt_restore_id,
    input  logic [WIDTH-1:0]                          i_retire_valid,
    input  logic [WIDTH-1:0][REG_IDX_SZ-1:0]          i_retire_arch,
    input  logic [WIDTH-1:0][PHYS_REG_IDX_SZ-1:0]     i_retire_preg,
    input  logic                                      i_flush
);

    MAP_T                   r_spec;
    MAP_T                   r_arch;
    logic [CKPT_IDX_SZ-1:0] r_head;
    logic [CKPT_IDX_SZ-1:0] r_tail;
    logic [CKPT_CNT_SZ-1:0] r_count;

    MAP_T                   w_spec_cdb;
    MAP_T                   w_spec_ren;
    MAP_T                   w_arch_nxt;
    MAP_T                   w_restore_map;
    MAP_T                   w_slot_map [NUM_CKPT];
    logic [NUM_CKPT-1:0]    w_slot_load;
    logic [NUM_CKPT-1:0]    w_slot_clear;
    logic                   w_full;
    logic                   w_alloc_eff;
    logic                   w_rel_eff;
    logic                   w_rst_rel;
    logic [CKPT_IDX_SZ-1:0] w_dist;

    assign w_full      = (r_count == CKPT_CNT_SZ'(NUM_CKPT));
    assign w_alloc_eff = i_ckpt_alloc && !w_full;
    assign w_rel_eff   = i_ckpt_release && (r_count != '0);
    assign w_dist      = i_ckpt_restore_id - r_head;
    assign w_rst_rel   = w_rel_eff && (w_dist != '0);

    assign o_ckpt_id   = r_tail;
    assign o_ckpt_full = w_full;

    assign w_spec_cdb    = apply_cdb(r_spec, i_cdb_valid, i_cdb_preg);
    assign w_restore_map = apply_cdb(w_slot_map[i_ckpt_restore_id], i_cdb_valid, i_cdb_preg);

    always_comb begin : rd_ports
        for (int unsigned j = 0; j < WIDTH; j++) begin
            o_src1_preg[j]     = bypass_read(i_src1_arch[j], j, i_dest_valid, i_dest_arch,
                                             i_dest_new_preg, w_spec_cdb);
            o_src2_preg[j]     = bypass_read(i_src2_arch[j], j, i_dest_valid, i_dest_arch,
                                             i_dest_new_preg, w_spec_cdb);
            o_dest_old_preg[j] = bypass_read(i_dest_arch[j], j, i_dest_valid, i_dest_arch,
                                             i_dest_new_preg, w_spec_cdb);
        end
    end

    // Lanes applied in order so the highest lane wins on a shared arch reg.
    always_comb begin : map_next
        w_spec_ren = w_spec_cdb;
        w_arch_nxt = r_arch;
        for (int unsigned j = 0; j < WIDTH; j++) begin
            if (i_dest_valid[j] && (i_dest_arch[j] != ZERO_REG)) begin
                w_spec_ren[i_dest_arch[j]] = '{reg_num: i_dest_new_preg[j], ready: 1'b0};
            end
            if (i_retire_valid[j] && (i_retire_arch[j] != ZERO_REG)) begin
                w_arch_nxt[i_retire_arch[j]] = '{reg_num: i_retire_preg[j], ready: 1'b1};
            end
        end
    end

    // Restore frees the restored slot and everything younger than it.
    always_comb begin : slot_ctrl
        w_slot_load  = '0;
        w_slot_clear = '0;
        for (int k = 0; k < int'(NUM_CKPT); k++) begin
            if (i_flush) begin
                w_slot_clear[k] = 1'b1;
            end else if (i_ckpt_restore) begin
                w_slot_clear[k] = ((CKPT_IDX_SZ'(k) - r_head) >= w_dist)
                               || (w_rst_rel && (CKPT_IDX_SZ'(k) == r_head));
            end else begin
                w_slot_load[k]  = w_alloc_eff && (CKPT_IDX_SZ'(k) == r_tail);
                w_slot_clear[k] = w_rel_eff && (CKPT_IDX_SZ'(k) == r_head);
            end
        end
    end

    for (genvar k = 0; k < NUM_CKPT; k++) begin : g_slot
        map_ckpt_slot u_slot (
            .clk         (clk),
            .reset       (reset),
            .i_load      (w_slot_load[k]),
            .i_load_map  (w_spec_ren),
            .i_clear     (w_slot_clear[k]),
            .i_cdb_valid (i_cdb_valid),
            .i_cdb_preg  (i_cdb_preg),
            .o_map       (w_slot_map[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_spec  <= identity_map();
            r_arch  <= identity_map();
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_arch <= w_arch_nxt;
            if (i_flush) begin
                r_spec  <= w_arch_nxt;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else if (i_ckpt_restore) begin
                r_spec  <= w_restore_map;
                r_tail  <= i_ckpt_restore_id;
                r_head  <= r_head + CKPT_IDX_SZ'(w_rst_rel);
                r_count <= {1'b0, w_dist} - CKPT_CNT_SZ'(w_rst_rel);
            end else begin
                r_spec  <= w_spec_ren;
                r_tail  <= r_tail + CKPT_IDX_SZ'(w_alloc_eff);
                r_head  <= r_head + CKPT_IDX_SZ'(w_rel_eff);
                r_count <= r_count + CKPT_CNT_SZ'(w_alloc_eff) - CKPT_CNT_SZ'(w_rel_eff);
            end
        end
    end

endmodule

// File: doc/map_table_ckpt.md
Name: map_table_ckpt

Overview:
- N-wide register rename map table with branch checkpoints and a retirement (architectural) map.
- Renames up to WIDTH instructions per cycle, with intra-group dependency bypass and CDB ready forwarding.
- Snapshots the speculative map into up to NUM_CKPT checkpoints for single-cycle branch recovery; full flush restores from the architectural map.
- Sits between decode/free list and the RS/ROB in the dispatch stage.

Parameters:
- ARCH_REGS, 32, number of architectural registers; index 0 is the hardwired zero register.
- PHYS_REGS, 64, number of physical registers.
- WIDTH, 2, rename lanes per cycle.
- CDB_WIDTH, 2, CDB broadcasts per cycle.
- NUM_CKPT, 4, checkpoint slots; power of 2.
- Derived: AW=$clog2(ARCH_REGS), PW=$clog2(PHYS_REGS), CW=$clog2(NUM_CKPT).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- src1_arch / src2_arch  in  WIDTH x AW  per-lane source architectural indices.
- src1_preg / src2_preg  out  WIDTH x PREG  per-lane mapping {reg_num[PW], ready}.
- dest_valid  in  WIDTH  lane renames its destination.
- dest_arch  in  WIDTH x AW  per-lane destination architectural index.
- dest_new_preg  in  WIDTH x PW  per-lane new physical register from the free list.
- dest_old_preg  out  WIDTH x PREG  previous mapping of dest_arch, sent to the ROB.
- cdb_valid  in  CDB_WIDTH  CDB broadcast valid.
- cdb_preg  in  CDB_WIDTH x PW  CDB physical register tag.
- ckpt_alloc  in  1  take a snapshot after this cycle's renames.
- ckpt_id  out  CW  slot that the current ckpt_alloc receives.
- ckpt_full  out  1  all slots in use.
- ckpt_release  in  1  oldest checkpoint's branch resolved correct.
- ckpt_restore  in  1  mispredict recovery.
- ckpt_restore_id  in  CW  checkpoint to restore.
- retire_valid  in  WIDTH  per-lane retirement.
- retire_arch  in  WIDTH x AW  retiring architectural index.
- retire_preg  in  WIDTH x PW  retiring physical register.
- flush  in  1  exception recovery to the architectural map.

Behaviour:
- Reset state:
  - spec and arch maps: entry i = {reg_num=i, ready=1}.
  - All checkpoints invalid; head=tail=count=0.
  - ckpt_full=0, ckpt_id=0.
  - Read outputs are combinational, so after reset they reflect the identity map.
- Reads (combinational, zero latency):
  - Lane j source: if the index is 0, the result is {0, ready=1}.
  - Otherwise, if the youngest lane k<j with dest_valid[k] and dest_arch[k] equals the source index exists, the result is {dest_new_preg[k], ready=0}.
  - Otherwise the result is the spec map entry. Its ready bit is OR'd with a hit on any valid cdb_preg.
- dest_old_preg[j]: same rule as a source read, applied to dest_arch[j]. It therefore sees earlier lanes' new dest in the same group.
- Rename write (posedge):
  - map[dest_arch[j]] <= {dest_new_preg[j], 0} for each valid lane with dest_arch != 0.
  - Same arch reg in several lanes: the highest lane wins.
  - Rename write beats a same-cycle CDB ready on that entry.
- CDB (posedge): every spec-map entry and every valid checkpoint entry whose reg_num matches a valid cdb_preg gets ready <= 1.
- Retire (posedge):
  - arch[retire_arch[j]] <= {retire_preg[j], 1}; highest lane wins.
  - Index 0 is ignored.
- Checkpoints (circular queue of NUM_CKPT snapshots):
  - ckpt_id = tail.
  - ckpt_alloc while !ckpt_full: snap[tail] <= spec map after this cycle's renames and CDB updates; tail++; count++.
  - ckpt_alloc while ckpt_full is ignored. Decode must stall.
  - ckpt_release with count>0: head++, count--. Release with count==0 is ignored.
  - ckpt_full = (count==NUM_CKPT).
- ckpt_restore:
  - spec map <= snap[ckpt_restore_id] with this cycle's CDB applied.
  - tail <= ckpt_restore_id; that slot and all younger slots are freed.
  - count <= (ckpt_restore_id - head) mod NUM_CKPT, minus 1 if a release occurs the same cycle.
  - The restore id must be valid.
  - Same-cycle renames and ckpt_alloc are dropped.
- flush:
  - spec map <= arch map including this cycle's retires.
  - Ready bits become 1.
  - All checkpoints are cleared (head=tail=count=0).
  - Renames, allocs and restores in the same cycle are dropped.
- Priority: reset > flush > ckpt_restore > rename/alloc. CDB and retire always apply.
- Wrap-around: head and tail are CW-bit counters that wrap modulo NUM_CKPT; count disambiguates full from empty.

Decomposition:
- Shared sys_defs package holds:
  - PREG struct.
  - PHYS_REG_IDX_SZ, REG_IDX_SZ, ZERO_REG.
  - MAP_T typedef (array of ARCH_REGS PREG).
- One sub-module, map_ckpt_slot: a single snapshot store with load, valid, and CDB ready update.
  - The top instantiates it NUM_CKPT times and owns the queue pointers, bypass logic and arch map.

Test Plan:
- Reset, then read src1_arch=5 → {5, ready 1}; dest_old_preg for arch 7 → {7, 1}.
- Lane0 dest r3→p40, lane1 src1=r3, same cycle → lane1 src1_preg={40,0}. Next cycle, CDB p40 → read r3 = {40,1}, and the map entry holds ready=1.
- Lane0 and lane1 both dest r4 (p41, p42) → lane1 dest_old_preg={41,0}; next cycle map[r4]=42.
- Rename r1→p50, ckpt_alloc (id 0), rename r1→p51, CDB p50, ckpt_restore id 0 → r1={50,1}, count=0, ckpt_id=0.
- Allocate 4 checkpoints → ckpt_full=1 and a fifth alloc is ignored. Release one → ckpt_full=0, next ckpt_id=0 (wrap).
- Retire r2→p45, rename r2→p46, flush → r2={45,1}, all checkpoints cleared, same-cycle rename dropped.
